// File: rtl/dds_sweep.sv
// rtl/dds_sweep.sv - linear frequency-sweep controller driving the dds cfg word
//
// Purpose:
//   Produces cfg = {dds_on, dds_inv, phase_inc[29:0]} for the downstream dds.
//   phase_inc starts at f_start and steps by f_step towards f_stop, holding
//   each value for dwell+1 clocks. One-shot or repeating sweeps.
//
// Parameters:
//   DWELL_W   width of the dwell port and hold counter
//   AUTO_OFF  1: cfg returns to 0 after a one-shot sweep; 0: last cfg is held
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous reset, active-low
//   start      in   1-cycle start pulse, honoured only while idle
//   abort      in   level, returns to idle and clears cfg; beats start
//   f_start    in   [29:0] first phase increment
//   f_stop     in   [29:0] last phase increment (clamp target)
//   f_step     in   [29:0] increment change per step
//   dwell      in   [DWELL_W-1:0] cycles per step minus one
//   repeat_en  in   1: sweep repeats until abort
//   inv        in   copied to cfg[30] while running
//   cfg        out  [31:0] dds configuration word
//   busy       out  high whenever not idle
//   done       out  1-cycle pulse when a one-shot sweep completes
//
// Optional feature macro: DDS_SWEEP_TRIANGLE_EN
//   Defined: after the up-ramp the block ramps back down to f_start
//   (triangle); f_stop and f_start are each dwelt only once per turn.
//   Undefined: up-ramp only; repeat reloads f_start (sawtooth).

module dds_sweep #(
  parameter int DWELL_W  = 16,
  parameter bit AUTO_OFF = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [29:0]        f_start,
  input  logic [29:0]        f_stop,
  input  logic [29:0]        f_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               repeat_en,
  input  logic               inv,
  output logic [31:0]        cfg,
  output logic               busy,
  output logic               done
);

  // The step itself costs no cycle: it is applied on the edge where the
  // dwell counter hits zero, so there is no separate STEP state register.
  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_DWELL      = 2'd1
`ifdef DDS_SWEEP_TRIANGLE_EN
    ,S_DOWN_DWELL = 2'd2
`endif
  } state_t;

  state_t             state;
  logic [29:0]        inc;
  logic [DWELL_W-1:0] cnt;

  // Parameters captured at start; input changes mid-sweep are ignored.
  logic [29:0]        lat_start;
  logic [29:0]        lat_stop;
  logic [29:0]        lat_step;
  logic [DWELL_W-1:0] lat_dwell;
  logic               lat_rpt;
  logic               lat_inv;

  // Up step: 31-bit sum so a large f_step cannot wrap past f_stop.
  logic [30:0] up_sum;
  logic [29:0] up_next;
  logic        up_end;

  always_comb begin
    up_sum  = {1'b0, inc} + {1'b0, lat_step};
    up_next = (up_sum >= {1'b0, lat_stop}) ? lat_stop : up_sum[29:0];
    // ">=" also covers f_start >= f_stop: one dwell at f_start, no overshoot.
    up_end  = (inc >= lat_stop);
  end

`ifdef DDS_SWEEP_TRIANGLE_EN
  // Down step clamps at f_start; compare against f_start+f_step in 31 bits
  // instead of subtracting first, so the difference never underflows.
  logic [30:0] dn_floor;
  logic [29:0] dn_next;
  logic        dn_end;
  logic [30:0] rs_sum;
  logic [29:0] rs_next;

  always_comb begin
    dn_floor = {1'b0, lat_start} + {1'b0, lat_step};
    dn_next  = ({1'b0, inc} <= dn_floor) ? lat_start : (inc - lat_step);
    dn_end   = (inc <= lat_start);
    // Restarting the up-ramp skips f_start, it was just dwelt on the way down.
    rs_sum   = {1'b0, lat_start} + {1'b0, lat_step};
    rs_next  = (rs_sum >= {1'b0, lat_stop}) ? lat_stop : rs_sum[29:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      inc       <= '0;
      cnt       <= '0;
      lat_start <= '0;
      lat_stop  <= '0;
      lat_step  <= '0;
      lat_dwell <= '0;
      lat_rpt   <= 1'b0;
      lat_inv   <= 1'b0;
      cfg       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
      cnt   <= '0;
      cfg   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            lat_start <= f_start;
            lat_stop  <= f_stop;
            lat_step  <= f_step;
            lat_dwell <= dwell;
            lat_rpt   <= repeat_en;
            lat_inv   <= inv;
            inc       <= f_start;
            cnt       <= dwell;
            cfg       <= {1'b1, inv, f_start};
            busy      <= 1'b1;
            state     <= S_DWELL;
          end
        end

        S_DWELL: begin
          if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if (!up_end) begin
            inc <= up_next;
            cfg <= {1'b1, lat_inv, up_next};
            cnt <= lat_dwell;
          end else begin
`ifdef DDS_SWEEP_TRIANGLE_EN
            // f_stop is left immediately for the first down value.
            if (inc > lat_start) begin
              inc   <= dn_next;
              cfg   <= {1'b1, lat_inv, dn_next};
              cnt   <= lat_dwell;
              state <= S_DOWN_DWELL;
            end else
`endif
            if (lat_rpt) begin
              inc <= lat_start;
              cfg <= {1'b1, lat_inv, lat_start};
              cnt <= lat_dwell;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
              if (AUTO_OFF) cfg <= '0;
            end
          end
        end

`ifdef DDS_SWEEP_TRIANGLE_EN
        S_DOWN_DWELL: begin
          if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if (!dn_end) begin
            inc <= dn_next;
            cfg <= {1'b1, lat_inv, dn_next};
            cnt <= lat_dwell;
          end else if (lat_rpt) begin
            inc   <= rs_next;
            cfg   <= {1'b1, lat_inv, rs_next};
            cnt   <= lat_dwell;
            state <= S_DWELL;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
            if (AUTO_OFF) cfg <= '0;
          end
        end
`endif

        default: begin
          state <= S_IDLE;
          cfg   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep.sv
// tb/tb_dds_sweep.sv - directed self-checking bench for dds_sweep

module tb_dds_sweep;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [29:0] f_start;
  logic [29:0] f_stop;
  logic [29:0] f_step;
  logic [15:0] dwell;
  logic        repeat_en;
  logic        inv;
  logic [31:0] cfg;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;
  int seq[$];

  always #5 clk = ~clk;

  dds_sweep dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .f_start   (f_start),
    .f_stop    (f_stop),
    .f_step    (f_step),
    .dwell     (dwell),
    .repeat_en (repeat_en),
    .inv       (inv),
    .cfg       (cfg),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Issue a start pulse; returns at the first negedge where the first value shows.
  task automatic kick(input logic [29:0] a, input logic [29:0] b, input logic [29:0] s,
                      input logic [15:0] d, input logic r, input logic iv);
    f_start = a; f_stop = b; f_step = s; dwell = d; repeat_en = r; inv = iv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Checks every value in seq, each held for 'hold' cycles, with no done pulse.
  task automatic play(input int hold, input logic iv, input string tag);
    for (int i = 0; i < seq.size(); i++) begin
      for (int k = 0; k < hold; k++) begin
        chk({tag, "_cfg"}, cfg, {1'b1, iv, 30'(seq[i])});
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        chk({tag, "_nodone"}, {31'b0, done}, 32'd0);
        tick();
      end
    end
  endtask

  task automatic expect_done(input string tag);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_busy0"}, {31'b0, busy}, 32'd0);
    chk({tag, "_cfg0"}, cfg, 32'h0);
    tick();
    chk({tag, "_done_1cyc"}, {31'b0, done}, 32'd0);
    chk({tag, "_idle_cfg"}, cfg, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0; repeat_en = 1'b0; inv = 1'b0;
    tick(); tick(); tick();
    chk("rst_cfg", cfg, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Test 2: 100..400 by 100, dwell 2
    kick(30'd100, 30'd400, 30'd100, 16'd2, 1'b0, 1'b0);
`ifdef DDS_SWEEP_TRIANGLE_EN
    seq = {100, 200, 300, 400, 300, 200, 100};
`else
    seq = {100, 200, 300, 400};
`endif
    play(3, 1'b0, "t2");
    expect_done("t2");

    // Test 3: clamp at 350, dwell 0
    kick(30'd100, 30'd350, 30'd100, 16'd0, 1'b0, 1'b0);
`ifdef DDS_SWEEP_TRIANGLE_EN
    seq = {100, 200, 300, 350, 250, 150, 100};
`else
    seq = {100, 200, 300, 350};
`endif
    play(1, 1'b0, "t3");
    expect_done("t3");

    // Test 4: repeat with inv, then abort mid-dwell
    kick(30'd100, 30'd400, 30'd100, 16'd2, 1'b1, 1'b1);
    chk("t4_first_word", cfg, 32'hC000_0064);
`ifdef DDS_SWEEP_TRIANGLE_EN
    seq = {100, 200, 300, 400, 300, 200, 100, 200, 300, 400, 300};
`else
    seq = {100, 200, 300, 400, 100, 200, 300, 400, 100};
`endif
    play(3, 1'b1, "t4");
    tick();  // second cycle of the next dwell
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_abort_cfg", cfg, 32'h0);
    chk("t4_abort_busy", {31'b0, busy}, 32'd0);
    chk("t4_abort_nodone", {31'b0, done}, 32'd0);
    tick();
    chk("t4_abort_stays", {31'b0, busy}, 32'd0);
    // start and abort together while idle: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t4_sa_busy", {31'b0, busy}, 32'd0);
    chk("t4_sa_cfg", cfg, 32'h0);
    tick();
    chk("t4_sa_idle", {31'b0, busy}, 32'd0);

    // Test 1: reset held 3 cycles mid-sweep
    kick(30'd100, 30'd400, 30'd100, 16'd2, 1'b1, 1'b1);
    tick(); tick(); tick(); tick();
    chk("t1_running", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    chk("t1_cfg", cfg, 32'h0);
    chk("t1_busy", {31'b0, busy}, 32'd0);
    chk("t1_done", {31'b0, done}, 32'd0);
    tick();
    chk("t1_idle_after", {31'b0, busy}, 32'd0);
    chk("t1_cfg_after", cfg, 32'h0);

    // Test 6a: f_start > f_stop -> single dwell at f_start
    kick(30'd500, 30'd200, 30'd100, 16'd1, 1'b0, 1'b0);
    seq = {500};
    play(2, 1'b0, "t6a");
    expect_done("t6a");

    // Test 6b: f_step 0 holds f_start until abort, start while busy ignored
    kick(30'd100, 30'd400, 30'd0, 16'd3, 1'b0, 1'b0);
    for (int c = 0; c < 1000; c++) begin
      if (c == 500) begin
        f_start = 30'd700; inv = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      chk("t6b_cfg", cfg, {2'b10, 30'd100});
      chk("t6b_busy", {31'b0, busy}, 32'd1);
      tick();
    end
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6b_abort_cfg", cfg, 32'h0);
    chk("t6b_abort_busy", {31'b0, busy}, 32'd0);
    chk("t6b_abort_done", {31'b0, done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
